// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between the requesting agents and the weighted round-robin arbiter.
interface weighted_rr_arbiter_if #(
    parameter int AGENTS_NUM   = 4,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int IDX_W = (AGENTS_NUM > 2) ? $clog2(AGENTS_NUM) : 1;

    logic [AGENTS_NUM-1:0]              requests_i;
    logic [AGENTS_NUM-1:0]              tail_i;
    logic [AGENTS_NUM*WEIGHT_WIDTH-1:0] weights_i;
    logic [AGENTS_NUM-1:0]              grants_o;
    logic                               grant_valid_o;
    logic [IDX_W-1:0]                   grant_idx_o;
    logic                               locked_o;

    // Agent side: drives requests, tails and weights; observes grants.
    modport master (
        output requests_i,
        output tail_i,
        output weights_i,
        input  grants_o,
        input  grant_valid_o,
        input  grant_idx_o,
        input  locked_o
    );

    // Arbiter side.
    modport slave (
        input  requests_i,
        input  tail_i,
        input  weights_i,
        output grants_o,
        output grant_valid_o,
        output grant_idx_o,
        output locked_o
    );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with packet locking.
// An agent keeps priority for up to Weff packets in a row; a multi-flit packet
// holds the arbiter until its tail flit is granted. Grants are combinational.
module weighted_rr_arbiter #(
    parameter int AGENTS_NUM   = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    weighted_rr_arbiter_if.slave  arb
);
    localparam int IDX_W = (AGENTS_NUM > 2) ? $clog2(AGENTS_NUM) : 1;

    typedef logic [IDX_W-1:0]        idx_t;
    typedef logic [WEIGHT_WIDTH-1:0] cnt_t;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t state_q, state_d;
    idx_t   ptr_q, ptr_d;
    cnt_t   cnt_q, cnt_d;
    idx_t   owner_q, owner_d;

    logic   scan_found;
    idx_t   scan_idx;
    logic   grant_hit;
    idx_t   grant_idx;
    logic   grant_tail;
    logic   complete;
    cnt_t   grant_weight;
    cnt_t   e_cnt;
    logic [WEIGHT_WIDTH:0] e_inc;

    // A zero weight field still grants one packet per turn.
    function automatic cnt_t eff_weight(input cnt_t w);
        return (w == '0) ? cnt_t'(1) : w;
    endfunction

    // Next agent after g, wrapping exactly at AGENTS_NUM.
    function automatic idx_t next_agent(input idx_t g);
        return (g == idx_t'(AGENTS_NUM - 1)) ? '0 : idx_t'(g + 1'b1);
    endfunction

    // Round-robin scan: first requester at or after ptr, modulo AGENTS_NUM.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < AGENTS_NUM; i++) begin
            int   k;
            idx_t k_idx;
            k = int'(ptr_q) + i;
            if (k >= AGENTS_NUM) begin
                k = k - AGENTS_NUM;
            end
            k_idx = idx_t'(k);
            if (!scan_found && arb.requests_i[k_idx]) begin
                scan_found = 1'b1;
                scan_idx   = k_idx;
            end
        end
    end

    // Grant selection: locked owner only while locked, otherwise the scan winner.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        if (state_q == LOCKED) begin
            grant_hit = arb.requests_i[owner_q];
            grant_idx = owner_q;
        end else begin
            grant_hit = scan_found;
            grant_idx = scan_idx;
        end
        grant_tail = grant_hit && arb.tail_i[grant_idx];
        complete   = grant_tail;
    end

    // Packet completion bookkeeping: stay on g while its weight allows, else move on.
    always_comb begin
        int base;
        base         = int'(grant_idx) * WEIGHT_WIDTH;
        grant_weight = eff_weight(arb.weights_i[base +: WEIGHT_WIDTH]);
        e_cnt        = (grant_idx == ptr_q) ? cnt_q : '0;
        e_inc        = {1'b0, e_cnt} + 1'b1;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        if (complete) begin
            if (e_inc < {1'b0, grant_weight}) begin
                ptr_d = grant_idx;
                cnt_d = e_inc[WEIGHT_WIDTH-1:0];
            end else begin
                ptr_d = next_agent(grant_idx);
                cnt_d = '0;
            end
        end
        if (state_q == UNLOCKED && grant_hit && !grant_tail) begin
            owner_d = grant_idx;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock on a non-tail grant, unlock when the owner's tail is granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (grant_hit && !grant_tail) state_d = LOCKED;
            LOCKED:   if (grant_tail)               state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    // FSM outputs and grant vector.
    always_comb begin
        arb.grants_o      = grant_hit ? (AGENTS_NUM'(1) << grant_idx) : '0;
        arb.grant_valid_o = grant_hit;
        arb.grant_idx_o   = grant_hit ? grant_idx : '0;
        arb.locked_o      = (state_q == LOCKED);
    end

    // Priority pointer, packet count and owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench for weighted_rr_arbiter: directed scenarios plus random traffic
// compared against a behavioural packet-level model.
module tb_weighted_rr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    weighted_rr_arbiter_if #(.AGENTS_NUM(N), .WEIGHT_WIDTH(WW)) bus ();
    weighted_rr_arbiter #(.AGENTS_NUM(N), .WEIGHT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    weighted_rr_arbiter_if #(.AGENTS_NUM(3), .WEIGHT_WIDTH(WW)) bus3 ();
    weighted_rr_arbiter #(.AGENTS_NUM(3), .WEIGHT_WIDTH(WW)) dut3 (
        .clk (clk),
        .rst (rst),
        .arb (bus3)
    );

    // Reference model state: who has priority, how many packets it has had, lock owner.
    int m_ptr, m_cnt, m_owner;
    bit m_locked;

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_owner = 0; m_locked = 0;
    endtask

    function automatic int model_grant(input logic [N-1:0] req);
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_ptr + off) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_complete(input int g, input logic [N*WW-1:0] w);
        int wf, e;
        wf = int'(w[g*WW +: WW]);
        if (wf == 0) wf = 1;
        e = (g == m_ptr) ? m_cnt : 0;
        if (e + 1 < wf) begin
            m_ptr = g; m_cnt = e + 1;
        end else begin
            m_ptr = (g + 1) % N; m_cnt = 0;
        end
    endtask

    task automatic model_clock(input logic [N-1:0] req, input logic [N-1:0] tail,
                               input logic [N*WW-1:0] w);
        int g;
        g = model_grant(req);
        if (g < 0) return;
        if (!m_locked) begin
            if (tail[g]) model_complete(g, w);
            else begin m_locked = 1; m_owner = g; end
        end else if (tail[g]) begin
            model_complete(g, w);
            m_locked = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check 1ns later, advance the model at the rising edge.
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] tail,
                        input logic [N*WW-1:0] w, input bit use_lit,
                        input logic [N-1:0] lit, input string tag);
        int g;
        logic [31:0] exp_g;
        bus.requests_i = req;
        bus.tail_i     = tail;
        bus.weights_i  = w;
        #1;
        g = model_grant(req);
        exp_g = (g < 0) ? 32'd0 : (32'd1 << g);
        check({tag, " grants"}, 32'(bus.grants_o), exp_g);
        check({tag, " valid"}, 32'(bus.grant_valid_o), (g < 0) ? 32'd0 : 32'd1);
        check({tag, " idx"}, 32'(bus.grant_idx_o), (g < 0) ? 32'd0 : 32'(g));
        check({tag, " locked"}, 32'(bus.locked_o), 32'(m_locked));
        if (use_lit) check({tag, " literal"}, 32'(bus.grants_o), 32'(lit));
        @(posedge clk);
        if (!rst) model_clock(req, tail, w);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N*WW-1:0] w_one, w_zero, w_cur;
    logic [N-1:0]    lits [9];
    logic [2:0]      lits3 [4];
    logic [N-1:0]    rq, tl;

    initial begin
        w_one  = {N{4'h1}};
        w_zero = '0;
        rst = 1'b1;
        bus.requests_i = '0; bus.tail_i = '0; bus.weights_i = '0;
        bus3.requests_i = '0; bus3.tail_i = '0; bus3.weights_i = '0;
        model_reset();
        @(negedge clk);

        // Reset state with no requests
        step(4'b0000, 4'b0000, w_one, 1, 4'b0000, "reset_idle");
        rst = 1'b0;
        step(4'b0000, 4'b0000, w_one, 1, 4'b0000, "idle");

        // Equal weights rotate one packet each
        lits[0] = 4'b0001; lits[1] = 4'b0010; lits[2] = 4'b0100; lits[3] = 4'b1000; lits[4] = 4'b0001;
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, w_one, 1, lits[i], "rr_w1");

        // Zero weights behave as weight 1
        reset_dut();
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, w_zero, 1, lits[i], "rr_w0");

        // Agent 0 weight 3
        reset_dut();
        lits[0] = 4'b0001; lits[1] = 4'b0001; lits[2] = 4'b0001; lits[3] = 4'b0010; lits[4] = 4'b0100;
        lits[5] = 4'b1000; lits[6] = 4'b0001; lits[7] = 4'b0001; lits[8] = 4'b0001;
        for (int i = 0; i < 9; i++) step(4'b1111, 4'b1111, 16'h1113, 1, lits[i], "rr_w3");

        // Four-flit packet from agent 2 holds off agent 0
        reset_dut();
        step(4'b0010, 4'b0010, w_one, 1, 4'b0010, "to_ptr2");
        step(4'b0101, 4'b0001, w_one, 1, 4'b0100, "pkt_f0");
        step(4'b0101, 4'b0001, w_one, 1, 4'b0100, "pkt_f1");
        step(4'b0101, 4'b0001, w_one, 1, 4'b0100, "pkt_f2");
        step(4'b0101, 4'b0101, w_one, 1, 4'b0100, "pkt_f3");
        step(4'b0101, 4'b0001, w_one, 1, 4'b0001, "pkt_after");

        // Locked owner bubble: agent 3 ignored
        reset_dut();
        step(4'b0010, 4'b0000, w_one, 1, 4'b0010, "lock_own1");
        step(4'b1000, 4'b1000, w_one, 1, 4'b0000, "bubble");
        step(4'b1010, 4'b1010, w_one, 1, 4'b0010, "own1_tail");
        step(4'b1000, 4'b1000, w_one, 1, 4'b1000, "after_bubble");

        // Reset mid-packet while locked on owner 3 with cnt 2
        reset_dut();
        step(4'b1000, 4'b1000, 16'h4111, 1, 4'b1000, "o3_p1");
        step(4'b1000, 4'b1000, 16'h4111, 1, 4'b1000, "o3_p2");
        step(4'b1000, 4'b0000, 16'h4111, 1, 4'b1000, "o3_lock");
        rst = 1'b1;
        model_reset();
        step(4'b1010, 4'b1010, 16'h4111, 1, 4'b0010, "rst_held");
        rst = 1'b0;
        step(4'b1010, 4'b1010, 16'h4111, 1, 4'b0010, "rst_after");

        // Weight lowered below the current count advances the pointer
        reset_dut();
        step(4'b0011, 4'b0011, 16'h1113, 1, 4'b0001, "wchg_a");
        step(4'b0011, 4'b0011, 16'h1113, 1, 4'b0001, "wchg_b");
        step(4'b0011, 4'b0011, 16'h1112, 1, 4'b0001, "wchg_c");
        step(4'b0011, 4'b0011, 16'h1112, 1, 4'b0010, "wchg_d");

        // Non-power-of-two wrap with three agents
        reset_dut();
        bus3.requests_i = 3'b111; bus3.tail_i = 3'b111; bus3.weights_i = '0;
        lits3[0] = 3'b001; lits3[1] = 3'b010; lits3[2] = 3'b100; lits3[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("n3_wrap", 32'(bus3.grants_o), 32'(lits3[i]));
            @(negedge clk);
        end
        bus3.requests_i = '0;

        // Random traffic against the model
        reset_dut();
        w_cur = 16'(w_one);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) w_cur = 16'($urandom);
            rq = 4'($urandom);
            tl = 4'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                model_reset();
                step(rq, tl, w_cur, 0, 4'b0000, "rnd_rst");
                rst = 1'b0;
            end else begin
                step(rq, tl, w_cur, 0, 4'b0000, "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
